axis_motion_ctrl: RTL and testbench
===================================

// Module: axis_motion_ctrl
// PURPOSE
//  Parametrised single-axis motion controller for the ship's spatial-position subsystem.
//  - One-hot mode (halt/attack/defense/stealth) plus a direction bit select a signed target
//    velocity; velocity ramps to the target by ACCEL per cycle.
//  - Position integrates the registered velocity every cycle; rate-limited warp jumps and
//    direct position load are supported.
//  - Three instances (x/y/z) form the 3-D position block.
// PARAMETERS
//  WIDTH          16      position/velocity width, two's-complement signed
//  ACCEL          1       max |velocity change| per cycle, must be >0
//  ATTACK_SPEED   8       |target velocity| in attack mode
//  DEFENSE_SPEED  4       |target velocity| in defense mode
//  STEALTH_SPEED  1       |target velocity| in stealth mode
//  WARP_DIST      1024    position jump applied by one warp
//  WARP_COOLDOWN  16      cycles after a warp during which warp_req is ignored
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous reset, active-high
//  mode_sel      in   4      one-hot: 0001 halt, 0010 attack, 0100 defense, 1000 stealth
//  dir           in   1      0 = positive, 1 = negative motion
//  warp_req      in   1      request warp jump (level, sampled each edge)
//  pos_load      in   1      load position from pos_load_val
//  pos_load_val  in   WIDTH  value to load
//  position      out  WIDTH  registered signed position
//  velocity      out  WIDTH  registered signed velocity
//  state         out  2      00 IDLE, 01 RAMP, 10 CRUISE, 11 WARP_COOL
//  warp_ack      out  1      1-cycle pulse, warp taken
//  mode_err      out  1      1 for the cycle after a non-one-hot mode_sel is sampled
//  pos_sat       out  1      position clamped this cycle (macro only, else tied 0)
// BEHAVIOUR
//  - Reset (async, rst=1): position=0, velocity=0, state=IDLE, warp_ack=0, mode_err=0,
//    pos_sat=0, cooldown counter=0, target=0.
//  - Target: halt->0; other modes: +SPEED if dir=0, -SPEED if dir=1. Recomputed every edge.
//    Non-one-hot mode_sel (incl. 0000): target keeps its previous value, mode_err=1 next cycle.
//  - Ramp, each edge: if |target-velocity| <= ACCEL then velocity<=target, else velocity moves
//    ACCEL toward target. Sign reversal ramps through zero (+8 -> -8 takes 16 cycles at ACCEL=1).
//  - Position update priority, per edge:
//    1. pos_load: position <= pos_load_val. velocity/state still update. Any warp_req is
//       ignored and not acked.
//    2. Warp taken (warp_req=1, state!=WARP_COOL, target!=0): position <= position +/-
//       WARP_DIST (sign from dir). Velocity is NOT added that cycle. warp_ack=1 next cycle.
//       Cooldown counter loads WARP_COOLDOWN and state goes to WARP_COOL.
//    3. Otherwise: position <= position + velocity, using the pre-edge velocity register.
//  - Refused warp (WARP_COOL, target=0, or pos_load): no ack, no queuing.
//  - FSM:
//    IDLE->RAMP when target!=velocity.
//    RAMP->CRUISE when velocity reaches a nonzero target; RAMP->IDLE when it reaches 0.
//    CRUISE->RAMP when target!=velocity.
//    WARP_COOL: velocity keeps ramping; counter decrements each edge. At counter==1, exits to
//      IDLE/RAMP/CRUISE per the rules above, evaluated on that edge's next velocity.
//  - Arithmetic: all add/sub in WIDTH bits, two's complement; overflow handling per CONFIGURATION.
//  - Latency: all outputs registered; an input change is visible one edge later.
// CONFIGURATION
//  AXIS_POS_SATURATE_EN defined:
//    - A position update that overflows clamps to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
//    - pos_sat=1 for that cycle.
//  AXIS_POS_SATURATE_EN undefined:
//    - position wraps modulo 2^WIDTH; pos_sat constant 0.
//  Velocity never overflows (bounded by the speed parameters).
// TESTING
//  1. Rest, mode 0010, dir 0 -> velocity 1,2..8 on edges 1-8; position 28 after edge 8;
//     state RAMP then CRUISE from edge 8.
//  2. CRUISE +8, mode 0001 -> velocity 7..0 over 8 edges; state RAMP then IDLE.
//  3. CRUISE +8 at position 100, warp_req 1 cycle -> position 1124, warp_ack 1 pulse,
//     state WARP_COOL. warp_req again 5 cycles later -> no ack, normal integration.
//  4. mode_sel 0110 during CRUISE +8 -> mode_err=1 one cycle, velocity stays 8.
//  5. pos_load 16'h7FFE with velocity +8 -> next edge 16'h7FFE.
//     Following edge: macro on -> 16'h7FFF, pos_sat=1; macro off -> 16'h8006, pos_sat=0.
//  6. rst mid-ramp, between clock edges -> all outputs at reset values immediately.
//     After release with mode 0010: ramp restarts from 0.

Source files
------------

// File: rtl/axis_motion_ctrl.sv
// Single-axis motion controller: mode/direction select a target velocity, velocity ramps by ACCEL,
// position integrates velocity, with rate-limited warp jumps. Build macro: AXIS_POS_SATURATE_EN.
module axis_motion_ctrl #(
    parameter int WIDTH         = 16,
    parameter int ACCEL         = 1,
    parameter int ATTACK_SPEED  = 8,
    parameter int DEFENSE_SPEED = 4,
    parameter int STEALTH_SPEED = 1,
    parameter int WARP_DIST     = 1024,
    parameter int WARP_COOLDOWN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       mode_sel,
    input  logic             dir,
    input  logic             warp_req,
    input  logic             pos_load,
    input  logic [WIDTH-1:0] pos_load_val,
    output logic [WIDTH-1:0] position,
    output logic [WIDTH-1:0] velocity,
    output logic [1:0]       state,
    output logic             warp_ack,
    output logic             mode_err,
    output logic             pos_sat
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_RAMP      = 2'b01,
        S_CRUISE    = 2'b10,
        S_WARP_COOL = 2'b11
    } state_t;

    localparam int CNT_W = $clog2(WARP_COOLDOWN + 2);
    localparam logic signed [WIDTH-1:0] ATTACK_V  = WIDTH'(ATTACK_SPEED);
    localparam logic signed [WIDTH-1:0] DEFENSE_V = WIDTH'(DEFENSE_SPEED);
    localparam logic signed [WIDTH-1:0] STEALTH_V = WIDTH'(STEALTH_SPEED);
    localparam logic signed [WIDTH-1:0] WARP_V    = WIDTH'(WARP_DIST);
    localparam logic signed [WIDTH-1:0] ACCEL_V   = WIDTH'(ACCEL);
    localparam logic signed [WIDTH:0]   ACCEL_X   = (WIDTH+1)'(ACCEL);
    localparam logic [CNT_W-1:0]        COOL_INIT = CNT_W'(WARP_COOLDOWN);
    localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);

    state_t                    state_q, state_d, settle_st;
    logic signed [WIDTH-1:0]   pos_q, pos_d;
    logic signed [WIDTH-1:0]   vel_q, vel_d;
    logic signed [WIDTH-1:0]   tgt_q, tgt_d;
    logic signed [WIDTH-1:0]   speed, addend;
    logic [CNT_W-1:0]          cool_q, cool_d;
    logic                      warp_ack_q, warp_ack_d;
    logic                      mode_err_q, mode_err_d;
    logic                      mode_ok, warp_take;

    // The difference is taken one bit wider so a full-scale reversal cannot wrap.
    function automatic logic signed [WIDTH-1:0] ramp_step(input logic signed [WIDTH-1:0] vel,
                                                          input logic signed [WIDTH-1:0] tgt);
        logic signed [WIDTH:0] diff;
        diff = {tgt[WIDTH-1], tgt} - {vel[WIDTH-1], vel};
        if (diff > ACCEL_X)
            ramp_step = vel + ACCEL_V;
        else if (diff < -ACCEL_X)
            ramp_step = vel - ACCEL_V;
        else
            ramp_step = tgt;
    endfunction

`ifdef AXIS_POS_SATURATE_EN
    localparam logic signed [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] POS_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic           pos_sat_q, pos_sat_d;
    logic [WIDTH:0] sum_ext;

    // Returns {overflow, clamped sum}.
    function automatic logic [WIDTH:0] pos_add(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sum;
        sum = a + b;
        if ((a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]))
            pos_add = {1'b1, (a[WIDTH-1] ? POS_MIN : POS_MAX)};
        else
            pos_add = {1'b0, sum};
    endfunction
`else
    function automatic logic signed [WIDTH-1:0] pos_add(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
        pos_add = a + b;
    endfunction
`endif

    always_comb begin
        mode_ok = (mode_sel != 4'b0000) && ((mode_sel & (mode_sel - 4'd1)) == 4'b0000);
        speed   = '0;
        case (mode_sel)
            4'b0010: speed = ATTACK_V;
            4'b0100: speed = DEFENSE_V;
            4'b1000: speed = STEALTH_V;
            default: speed = '0;
        endcase
        tgt_d = tgt_q;
        if (mode_ok)
            tgt_d = dir ? -speed : speed;
        vel_d      = ramp_step(vel_q, tgt_d);
        mode_err_d = !mode_ok;

        // A warp replaces the velocity term for this edge rather than adding to it.
        warp_take  = warp_req && !pos_load && (state_q != S_WARP_COOL) && (tgt_d != '0);
        warp_ack_d = warp_take;
        addend     = warp_take ? (dir ? -WARP_V : WARP_V) : vel_q;
`ifdef AXIS_POS_SATURATE_EN
        sum_ext   = pos_add(pos_q, addend);
        pos_sat_d = !pos_load && sum_ext[WIDTH];
        pos_d     = pos_load ? pos_load_val : sum_ext[WIDTH-1:0];
`else
        pos_d     = pos_load ? pos_load_val : pos_add(pos_q, addend);
`endif
    end

    always_comb begin
        state_d   = state_q;
        cool_d    = cool_q;
        settle_st = (vel_d != tgt_d) ? S_RAMP : ((tgt_d != '0) ? S_CRUISE : S_IDLE);
        case (state_q)
            S_IDLE:   if (tgt_d != vel_q) state_d = S_RAMP;
            S_RAMP:   if (vel_d == tgt_d) state_d = settle_st;
            S_CRUISE: if (tgt_d != vel_q) state_d = S_RAMP;
            S_WARP_COOL: begin
                cool_d = cool_q - CNT_ONE;
                if (cool_q <= CNT_ONE) begin
                    state_d = settle_st;
                    cool_d  = '0;
                end
            end
            default:  state_d = S_IDLE;
        endcase
        if (warp_take) begin
            state_d = S_WARP_COOL;
            cool_d  = COOL_INIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pos_q      <= '0;
            vel_q      <= '0;
            tgt_q      <= '0;
            cool_q     <= '0;
            warp_ack_q <= 1'b0;
            mode_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            vel_q      <= vel_d;
            tgt_q      <= tgt_d;
            cool_q     <= cool_d;
            warp_ack_q <= warp_ack_d;
            mode_err_q <= mode_err_d;
        end
    end

`ifdef AXIS_POS_SATURATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pos_sat_q <= 1'b0;
        else
            pos_sat_q <= pos_sat_d;
    end

    assign pos_sat = pos_sat_q;
`else
    assign pos_sat = 1'b0;
`endif

    assign position = pos_q;
    assign velocity = vel_q;
    assign state    = state_q;
    assign warp_ack = warp_ack_q;
    assign mode_err = mode_err_q;
endmodule

// File: tb/tb_axis_motion_ctrl.sv
// Scoreboard bench for axis_motion_ctrl: the driver queues hand-computed expectations per edge,
// a monitor pops and compares them just after each rising edge.
module tb_axis_motion_ctrl;
    localparam logic [3:0] M_HALT = 4'b0001;
    localparam logic [3:0] M_ATK  = 4'b0010;
    localparam logic [3:0] M_DEF  = 4'b0100;
    localparam logic [3:0] M_STL  = 4'b1000;
    localparam int ST_IDLE = 0, ST_RAMP = 1, ST_CRUISE = 2, ST_COOL = 3;
    localparam int F_POS = 1, F_VEL = 2, F_ST = 4, F_ACK = 8, F_ERR = 16, F_SAT = 32, F_ALL = 63;
`ifdef AXIS_POS_SATURATE_EN
    localparam int SAT_EN = 1;
`else
    localparam int SAT_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mode_sel;
    logic        dir, warp_req, pos_load;
    logic [15:0] pos_load_val;
    logic [15:0] position, velocity;
    logic [1:0]  state;
    logic        warp_ack, mode_err, pos_sat;

    axis_motion_ctrl dut (
        .clk(clk), .rst(rst), .mode_sel(mode_sel), .dir(dir), .warp_req(warp_req),
        .pos_load(pos_load), .pos_load_val(pos_load_val), .position(position),
        .velocity(velocity), .state(state), .warp_ack(warp_ack), .mode_err(mode_err),
        .pos_sat(pos_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    mask;
        int    pos, vel, st, ack, err, sat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   dn_pos [8] = '{84, 91, 97, 102, 106, 109, 111, 112};
    int   stl_vel[5] = '{3, 2, 1, 0, 16'hFFFF};

    task automatic chk(input string name, input string fld, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h, expected %h", name, fld, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] m, input logic d, input logic w, input logic l,
                         input logic [15:0] lv);
        mode_sel = m; dir = d; warp_req = w; pos_load = l; pos_load_val = lv;
    endtask

    task automatic tick(input string name, input int mask, input int pos, input int vel,
                        input int st, input int ack, input int err, input int sat);
        exp_t e;
        e.name = name; e.mask = mask; e.pos = pos; e.vel = vel;
        e.st = st; e.ack = ack; e.err = err; e.sat = sat;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, "position", position, 16'h0);
        chk(name, "velocity", velocity, 16'h0);
        chk(name, "state", 16'(state), 16'(ST_IDLE));
        chk(name, "warp_ack", 16'(warp_ack), 16'h0);
        chk(name, "mode_err", 16'(mode_err), 16'h0);
        chk(name, "pos_sat", 16'(pos_sat), 16'h0);
    endtask

    always @(posedge clk) begin
        exp_t cur;
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            if ((cur.mask & F_POS) != 0) chk(cur.name, "position", position, 16'(cur.pos));
            if ((cur.mask & F_VEL) != 0) chk(cur.name, "velocity", velocity, 16'(cur.vel));
            if ((cur.mask & F_ST)  != 0) chk(cur.name, "state", 16'(state), 16'(cur.st));
            if ((cur.mask & F_ACK) != 0) chk(cur.name, "warp_ack", 16'(warp_ack), 16'(cur.ack));
            if ((cur.mask & F_ERR) != 0) chk(cur.name, "mode_err", 16'(mode_err), 16'(cur.err));
            if ((cur.mask & F_SAT) != 0) chk(cur.name, "pos_sat", 16'(pos_sat), 16'(cur.sat));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(M_HALT, 1'b0, 1'b0, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        chk_reset_vals("reset_state");
        rst = 1'b0;

        drive(M_ATK, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 1; k <= 8; k++)
            tick("ramp_up", F_ALL, k * (k - 1) / 2, k, (k < 8) ? ST_RAMP : ST_CRUISE, 0, 0, 0);
        tick("cruise", F_ALL, 36, 8, ST_CRUISE, 0, 0, 0);
        tick("cruise", F_ALL, 44, 8, ST_CRUISE, 0, 0, 0);

        drive(4'b0110, 1'b0, 1'b0, 1'b0, 16'h0);
        tick("mode_0110", F_ALL, 52, 8, ST_CRUISE, 0, 1, 0);
        drive(M_ATK, 1'b0, 1'b0, 1'b0, 16'h0);
        tick("mode_ok", F_ALL, 60, 8, ST_CRUISE, 0, 0, 0);
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 16'h0);
        tick("mode_0000", F_ALL, 68, 8, ST_CRUISE, 0, 1, 0);
        drive(M_ATK, 1'b0, 1'b0, 1'b0, 16'h0);
        tick("mode_ok2", F_ALL, 76, 8, ST_CRUISE, 0, 0, 0);

        drive(M_HALT, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 1; k <= 8; k++)
            tick("ramp_down", F_ALL, dn_pos[k-1], 8 - k, (k < 8) ? ST_RAMP : ST_IDLE, 0, 0, 0);
        tick("idle_hold", F_ALL, 112, 0, ST_IDLE, 0, 0, 0);

        drive(M_ATK, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 1; k <= 8; k++)
            tick("ramp_up2", F_ALL, 112 + k * (k - 1) / 2, k, (k < 8) ? ST_RAMP : ST_CRUISE,
                 0, 0, 0);

        drive(M_ATK, 1'b0, 1'b0, 1'b1, 16'd100);
        tick("load_100", F_ALL, 100, 8, ST_CRUISE, 0, 0, 0);
        drive(M_ATK, 1'b0, 1'b1, 1'b0, 16'h0);
        tick("warp_pos", F_ALL, 1124, 8, ST_COOL, 1, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            drive(M_ATK, 1'b0, (k == 5), 1'b0, 16'h0);
            tick("cooldown", F_ALL, 1124 + 8 * k, 8, (k < 16) ? ST_COOL : ST_CRUISE, 0, 0, 0);
        end

        drive(M_ATK, 1'b0, 1'b1, 1'b1, 16'd500);
        tick("load_beats_warp", F_ALL, 500, 8, ST_CRUISE, 0, 0, 0);
        drive(M_HALT, 1'b0, 1'b1, 1'b0, 16'h0);
        tick("warp_tgt0", F_ALL, 508, 7, ST_RAMP, 0, 0, 0);
        drive(M_ATK, 1'b1, 1'b1, 1'b0, 16'h0);
        tick("warp_neg", F_ALL, 16'hFDFC, 6, ST_COOL, 1, 0, 0);
        drive(M_ATK, 1'b1, 1'b0, 1'b0, 16'h0);
        tick("cool_neg", F_ALL, 16'hFE02, 5, ST_COOL, 0, 0, 0);

        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        drive(M_ATK, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk_reset_vals("reset_held");
        rst = 1'b0;
        for (int k = 1; k <= 8; k++)
            tick("ramp_after_rst", F_ALL, k * (k - 1) / 2, k,
                 (k < 8) ? ST_RAMP : ST_CRUISE, 0, 0, 0);

        drive(M_ATK, 1'b0, 1'b0, 1'b1, 16'h7FFE);
        tick("load_7ffe", F_ALL, 16'h7FFE, 8, ST_CRUISE, 0, 0, 0);
        drive(M_ATK, 1'b0, 1'b0, 1'b0, 16'h0);
        tick("pos_overflow", F_ALL, (SAT_EN != 0) ? 16'h7FFF : 16'h8006, 8, ST_CRUISE, 0, 0,
             SAT_EN);
        drive(M_ATK, 1'b0, 1'b0, 1'b1, 16'h0);
        tick("load_0", F_ALL, 0, 8, ST_CRUISE, 0, 0, 0);

        drive(M_DEF, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int k = 1; k <= 4; k++)
            tick("defense", F_VEL | F_ST, 0, 8 - k, (k < 4) ? ST_RAMP : ST_CRUISE, 0, 0, 0);
        drive(M_STL, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int k = 1; k <= 5; k++)
            tick("stealth_neg", F_VEL | F_ST, 0, stl_vel[k-1], (k < 5) ? ST_RAMP : ST_CRUISE,
                 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
